// File: rtl/rca_lsu_arbiter.sv
// ---------------------------------------------------------------------------
// rca_lsu_arbiter
//
// Shares a single LSU between the scalar core and the RCA load/store queue.
// The core owns the LSU by default. When the RCA asserts rca_lsu_lock, the
// arbiter stops accepting core requests and waits for every in-flight core
// load to write back. It then hands the LSU to the RCA until the lock drops
// and the RCA's own loads have drained.
//
// Load writebacks return in order. A small tag FIFO records who issued each
// accepted load (0 = core, 1 = RCA). The head tag steers each lsu_wb_valid
// to the right requester in the same cycle.
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   core_* (in)               core request: valid, rs1, rs2, fn3, load, store
//   core_ready (out)          core request accepted this cycle
//   rca_* (in)                RCA request: valid, rs1, rs2, fn3, load, store
//   rca_lsu_lock (in)         RCA asks for exclusive LSU ownership
//   rca_ready (out)           RCA request accepted this cycle
//   lsu_* (out)               request forwarded to the LSU
//   lsu_ready, lsu_wb_* (in)  LSU handshake and load writeback
//   core_wb_*, rca_wb_* (out) routed writeback
//   owner (out)               0 IDLE, 1 CORE, 2 DRAIN_CORE, 3 RCA
// ---------------------------------------------------------------------------
module rca_lsu_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  // core request
  input  logic            core_new_request,
  input  logic [XLEN-1:0] core_rs1,
  input  logic [XLEN-1:0] core_rs2,
  input  logic [2:0]      core_fn3,
  input  logic            core_load,
  input  logic            core_store,
  output logic            core_ready,
  // RCA request
  input  logic            rca_new_request,
  input  logic [XLEN-1:0] rca_rs1,
  input  logic [XLEN-1:0] rca_rs2,
  input  logic [2:0]      rca_fn3,
  input  logic            rca_load,
  input  logic            rca_store,
  input  logic            rca_lsu_lock,
  output logic            rca_ready,
  // LSU side
  output logic            lsu_new_request,
  output logic [XLEN-1:0] lsu_rs1,
  output logic [XLEN-1:0] lsu_rs2,
  output logic [2:0]      lsu_fn3,
  output logic            lsu_load,
  output logic            lsu_store,
  input  logic            lsu_ready,
  input  logic            lsu_wb_valid,
  input  logic [XLEN-1:0] lsu_wb_data,
  // writeback routing
  output logic            core_wb_valid,
  output logic [XLEN-1:0] core_wb_data,
  output logic            rca_wb_valid,
  output logic [XLEN-1:0] rca_wb_data,
  output logic [1:0]      owner
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CORE       = 2'd1,
    ST_DRAIN_CORE = 2'd2,
    ST_RCA        = 2'd3
  } state_e;

  state_e                     state_q, state_d;
  logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic [MAX_OUTSTANDING-1:0] tag_q;

  logic full, empty, sel_rca, push, pop, head_tag;

  assign full    = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign empty   = (count_q == '0);
  assign sel_rca = (state_q == ST_RCA);

  // The handshakes are gated with rst so that they stay low while reset is
  // held, even if lsu_ready and the requests are already high.
  assign core_ready = rst & lsu_ready & ~full & ~rca_lsu_lock &
                      ((state_q == ST_IDLE) | (state_q == ST_CORE));
  assign rca_ready  = rst & lsu_ready & ~full & sel_rca;

  assign lsu_new_request = (core_new_request & core_ready) |
                           (rca_new_request  & rca_ready);

  assign lsu_rs1   = sel_rca ? rca_rs1   : core_rs1;
  assign lsu_rs2   = sel_rca ? rca_rs2   : core_rs2;
  assign lsu_fn3   = sel_rca ? rca_fn3   : core_fn3;
  assign lsu_load  = sel_rca ? rca_load  : core_load;
  assign lsu_store = sel_rca ? rca_store : core_store;

  // Only loads expect a writeback, so only they take a tag. A writeback with
  // no tag in the FIFO is stray and is dropped.
  assign push     = lsu_new_request & lsu_load;
  assign pop      = rst & lsu_wb_valid & ~empty;
  assign head_tag = tag_q[rd_ptr_q];

  assign core_wb_valid = pop & ~head_tag;
  assign rca_wb_valid  = pop & head_tag;
  assign core_wb_data  = lsu_wb_data;
  assign rca_wb_data   = lsu_wb_data;
  assign owner         = state_q;

  // Tag storage: each entry is written only when the write pointer selects it.
  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        tag_q[gi] <= 1'b0;
      end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
        tag_q[gi] <= sel_rca;
      end
    end
  end

  // Next state and FIFO bookkeeping
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        if (rca_lsu_lock) begin
          state_d = empty ? ST_RCA : ST_DRAIN_CORE;
        end else if (core_new_request) begin
          state_d = ST_CORE;
        end
      end
      ST_CORE: begin
        if (rca_lsu_lock) begin
          state_d = ST_DRAIN_CORE;
        end
      end
      ST_DRAIN_CORE: begin
        if (empty) begin
          state_d = ST_RCA;
        end
      end
      ST_RCA: begin
        // Keep RCA ownership until its own loads have come back, so that
        // the core never sees an RCA writeback.
        if (!rca_lsu_lock && empty) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Pointers are exactly PTR_W bits wide, so they wrap naturally.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_rca_lsu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rca_lsu_arbiter
//
// Directed scenarios followed by a randomized run. Each one is checked every
// cycle against a reference model. The model keeps the in-flight load owners
// in a queue and tracks ownership with a plain integer state.
// ---------------------------------------------------------------------------
module tb_rca_lsu_arbiter;

  localparam int XLEN    = 32;
  localparam int MAX_OUT = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            core_new_request, core_load, core_store;
  logic [XLEN-1:0] core_rs1, core_rs2;
  logic [2:0]      core_fn3;
  logic            rca_new_request, rca_load, rca_store, rca_lsu_lock;
  logic [XLEN-1:0] rca_rs1, rca_rs2;
  logic [2:0]      rca_fn3;
  logic            lsu_ready, lsu_wb_valid;
  logic [XLEN-1:0] lsu_wb_data;
  logic            core_ready, rca_ready, lsu_new_request, lsu_load, lsu_store;
  logic [XLEN-1:0] lsu_rs1, lsu_rs2;
  logic [2:0]      lsu_fn3;
  logic            core_wb_valid, rca_wb_valid;
  logic [XLEN-1:0] core_wb_data, rca_wb_data;
  logic [1:0]      owner;

  int tests = 0;
  int fails = 0;

  // reference model: 0 idle, 1 core, 2 drain, 3 rca; queue of load owners
  int m_state = 0;
  bit m_q[$];

  always #5 clk = ~clk;

  rca_lsu_arbiter #(.XLEN(XLEN), .MAX_OUTSTANDING(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .core_new_request(core_new_request), .core_rs1(core_rs1), .core_rs2(core_rs2),
    .core_fn3(core_fn3), .core_load(core_load), .core_store(core_store),
    .core_ready(core_ready),
    .rca_new_request(rca_new_request), .rca_rs1(rca_rs1), .rca_rs2(rca_rs2),
    .rca_fn3(rca_fn3), .rca_load(rca_load), .rca_store(rca_store),
    .rca_lsu_lock(rca_lsu_lock), .rca_ready(rca_ready),
    .lsu_new_request(lsu_new_request), .lsu_rs1(lsu_rs1), .lsu_rs2(lsu_rs2),
    .lsu_fn3(lsu_fn3), .lsu_load(lsu_load), .lsu_store(lsu_store),
    .lsu_ready(lsu_ready), .lsu_wb_valid(lsu_wb_valid), .lsu_wb_data(lsu_wb_data),
    .core_wb_valid(core_wb_valid), .core_wb_data(core_wb_data),
    .rca_wb_valid(rca_wb_valid), .rca_wb_data(rca_wb_data),
    .owner(owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    core_new_request = 1'b0; core_load = 1'b0; core_store = 1'b0;
    core_rs1 = $urandom; core_rs2 = $urandom; core_fn3 = 3'($urandom_range(0, 7));
    rca_new_request = 1'b0; rca_load = 1'b0; rca_store = 1'b0;
    rca_rs1 = $urandom; rca_rs2 = $urandom; rca_fn3 = 3'($urandom_range(0, 7));
    lsu_ready = 1'b1; lsu_wb_valid = 1'b0; lsu_wb_data = $urandom;
  endtask

  task automatic core_ld();
    core_new_request = 1'b1; core_load = 1'b1; core_store = 1'b0;
    core_rs1 = $urandom; core_rs2 = $urandom;
  endtask

  task automatic rca_ld();
    rca_new_request = 1'b1; rca_load = 1'b1; rca_store = 1'b0;
    rca_rs1 = $urandom; rca_rs2 = $urandom;
  endtask

  task automatic wb();
    lsu_wb_valid = 1'b1; lsu_wb_data = $urandom;
  endtask

  task automatic rand_inputs();
    core_new_request = 1'($urandom_range(0, 1));
    core_load  = 1'($urandom_range(0, 1)); core_store = ~core_load;
    core_rs1 = $urandom; core_rs2 = $urandom; core_fn3 = 3'($urandom_range(0, 7));
    rca_new_request = 1'($urandom_range(0, 1));
    rca_load   = 1'($urandom_range(0, 1)); rca_store = ~rca_load;
    rca_rs1 = $urandom; rca_rs2 = $urandom; rca_fn3 = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 7) == 0) rca_lsu_lock = ~rca_lsu_lock;
    lsu_ready    = ($urandom_range(0, 3) != 0);
    lsu_wb_valid = ($urandom_range(0, 9) < 4);
    lsu_wb_data  = $urandom;
  endtask

  // Called just after a falling edge with inputs already applied: checks all
  // outputs against the model, advances the model across the rising edge, and
  // returns at the next falling edge.
  task automatic step();
    int n;
    bit full, sel, e_cr, e_rr, acc, e_load, pop, head;
    logic [XLEN-1:0] e_rs1, e_rs2;
    logic [2:0] e_fn3;
    bit e_st;
    #1;
    n    = m_q.size();
    full = (n == MAX_OUT);
    sel  = (m_state == 3);
    head = (n > 0) ? m_q[0] : 1'b0;
    e_cr = lsu_ready && !full && !rca_lsu_lock && (m_state == 0 || m_state == 1);
    e_rr = lsu_ready && !full && sel;
    acc  = (core_new_request && e_cr) || (rca_new_request && e_rr);
    e_rs1  = sel ? rca_rs1   : core_rs1;
    e_rs2  = sel ? rca_rs2   : core_rs2;
    e_fn3  = sel ? rca_fn3   : core_fn3;
    e_load = sel ? rca_load  : core_load;
    e_st   = sel ? rca_store : core_store;
    pop  = lsu_wb_valid && (n > 0);

    check("core_ready",      {31'd0, core_ready},      {31'd0, e_cr});
    check("rca_ready",       {31'd0, rca_ready},       {31'd0, e_rr});
    check("lsu_new_request", {31'd0, lsu_new_request}, {31'd0, acc});
    check("lsu_rs1",         lsu_rs1,                  e_rs1);
    check("lsu_rs2",         lsu_rs2,                  e_rs2);
    check("lsu_fn3",         {29'd0, lsu_fn3},         {29'd0, e_fn3});
    check("lsu_load",        {31'd0, lsu_load},        {31'd0, e_load});
    check("lsu_store",       {31'd0, lsu_store},       {31'd0, e_st});
    check("core_wb_valid",   {31'd0, core_wb_valid},   {31'd0, pop && !head});
    check("rca_wb_valid",    {31'd0, rca_wb_valid},    {31'd0, pop && head});
    check("core_wb_data",    core_wb_data,             lsu_wb_data);
    check("rca_wb_data",     rca_wb_data,              lsu_wb_data);
    check("owner",           {30'd0, owner},           32'(m_state));

    if (acc)
      $display("[TB] %0t accept %s %s rs1=%h", $time, sel ? "rca" : "core",
               e_load ? "load" : "store", e_rs1);
    if (pop)
      $display("[TB] %0t writeback %h -> %s", $time, lsu_wb_data, head ? "rca" : "core");

    @(posedge clk);
    case (m_state)
      0: if (rca_lsu_lock) m_state = (n == 0) ? 3 : 2;
         else if (core_new_request) m_state = 1;
      1: if (rca_lsu_lock) m_state = 2;
      2: if (n == 0) m_state = 3;
      default: if (!rca_lsu_lock && n == 0) m_state = 0;
    endcase
    if (pop) void'(m_q.pop_front());
    if (acc && e_load) m_q.push_back(sel);
    @(negedge clk);
  endtask

  task automatic wait_owner(input logic [1:0] target, input string tag);
    int k;
    k = 0;
    while (owner !== target && k < 8) begin
      step();
      k++;
    end
    check(tag, {30'd0, owner}, {30'd0, target});
  endtask

  // Reset asserted in the middle of a low clock phase with live requests.
  task automatic reset_mid();
    core_ld(); lsu_ready = 1'b1; wb();
    #2 rst = 1'b0;
    #1;
    check("rst_core_ready", {31'd0, core_ready},      32'd0);
    check("rst_rca_ready",  {31'd0, rca_ready},       32'd0);
    check("rst_lsu_new",    {31'd0, lsu_new_request}, 32'd0);
    check("rst_core_wb",    {31'd0, core_wb_valid},   32'd0);
    check("rst_rca_wb",     {31'd0, rca_wb_valid},    32'd0);
    check("rst_owner",      {30'd0, owner},           32'd0);
    m_q.delete();
    m_state = 0;
    @(negedge clk);
    rst = 1'b1;
    $display("[TB] %0t reset released", $time);
  endtask

  initial begin
    rst = 1'b0;
    rca_lsu_lock = 1'b0;
    idle_inputs();
    core_ld();
    wb();
    @(negedge clk);
    #1;
    check("init_core_ready", {31'd0, core_ready},    32'd0);
    check("init_owner",      {30'd0, owner},         32'd0);
    check("init_core_wb",    {31'd0, core_wb_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // core-only: three loads, then three writebacks to the core
    idle_inputs();
    repeat (3) begin core_ld(); step(); end
    idle_inputs();
    check("s1_owner_core", {30'd0, owner}, 32'd1);
    repeat (3) begin wb(); step(); end

    // lock handover with two core loads in flight
    idle_inputs();
    repeat (2) begin core_ld(); step(); end
    idle_inputs(); rca_lsu_lock = 1'b1; core_ld();
    step();
    check("s2_owner_drain", {30'd0, owner}, 32'd2);
    idle_inputs();
    repeat (2) begin wb(); step(); idle_inputs(); end
    wait_owner(2'd3, "s2_owner_rca");
    rca_ld();
    #1;
    check("s2_rca_ready", {31'd0, rca_ready}, 32'd1);
    step();

    // release with one RCA load outstanding
    idle_inputs(); rca_lsu_lock = 1'b0;
    repeat (2) begin step(); check("s5_owner_hold", {30'd0, owner}, 32'd3); end
    wb();
    #1;
    check("s5_rca_wb", {31'd0, rca_wb_valid}, 32'd1);
    step();
    idle_inputs();
    wait_owner(2'd0, "s5_owner_idle");

    // full FIFO: four loads, refill after a writeback
    repeat (4) begin core_ld(); step(); end
    core_ld();
    #1;
    check("s3_full_core_ready", {31'd0, core_ready}, 32'd0);
    step();
    core_ld(); wb(); step();
    idle_inputs(); core_ld(); step();
    core_ld();
    #1;
    check("s3_refull_core_ready", {31'd0, core_ready}, 32'd0);
    step();
    idle_inputs(); rca_lsu_lock = 1'b1;
    repeat (4) begin wb(); step(); idle_inputs(); end
    wait_owner(2'd3, "s3_owner_rca");

    // mixed order: core load, lock, RCA load -> core then RCA writeback
    rca_lsu_lock = 1'b0;
    wait_owner(2'd0, "s4_owner_idle");
    core_ld(); step();
    idle_inputs(); rca_lsu_lock = 1'b1; step();
    wb();
    #1;
    check("s4_core_wb", {31'd0, core_wb_valid}, 32'd1);
    step();
    idle_inputs();
    wait_owner(2'd3, "s4_owner_rca");
    rca_ld(); step();
    idle_inputs(); wb();
    #1;
    check("s4_rca_wb", {31'd0, rca_wb_valid}, 32'd1);
    step();

    // reset with three RCA loads in flight
    idle_inputs();
    repeat (3) begin rca_ld(); step(); end
    reset_mid();
    idle_inputs(); rca_lsu_lock = 1'b0; core_ld(); step();
    check("s6_owner_core", {30'd0, owner}, 32'd1);
    idle_inputs(); wb();
    #1;
    check("s6_core_wb", {31'd0, core_wb_valid}, 32'd1);
    step();
    wb();
    #1;
    check("s6_empty_wb", {31'd0, core_wb_valid}, 32'd0);
    step();

    // randomized traffic with one reset in the middle
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      if (i == 200) reset_mid();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
